is_uart_rx_ovs: RTL and testbench
=================================

Name: is_uart_rx_ovs

Overview:
- Parametrised successor to the bit-rate UART receive FSM.
- Receives asynchronous serial frames using an oversampled clock-enable, with 3-sample majority voting at mid-bit and false-start rejection.
- Supports configurable data width, parity mode and stop-bit count.
- Delivers each frame through a single-entry valid/ready holding register, with parity, framing, overrun and break flags.
- Sits between the RXD input synchroniser and the UART controller register file.

Parameters:
- DATA_W, 8, data bits per frame, legal range 5..9, LSB transmitted first.
- OVS, 16, rx_ce_i ticks per bit period, legal range 8..32, even values only.
- PARITY, 4, parity mode: 0 none, 1 even, 2 odd, 3 mark, 4 space.
- STOP_BITS, 2, stop bits checked, legal values 1 or 2.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  reset, synchronous, active-high.
- rxd_i  in  1  serial line, already synchronised to clk_i; idle level high.
- rx_ce_i  in  1  single-cycle strobe at OVS x baud rate.
- rx_ready_i  in  1  consumer accepts the held frame this cycle.
- err_clr_i  in  1  clears overrun_o.
- rx_data_o  out  DATA_W  received data from the holding register.
- rx_valid_o  out  1  holding register contains an unread frame.
- parity_err_o  out  1  parity error of the held frame; always 0 when PARITY=0.
- frame_err_o  out  1  at least one stop bit of the held frame sampled low.
- overrun_o  out  1  sticky: a completed frame was dropped because the holding register was full.
- break_o  out  1  break condition present.
- busy_o  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (rstn_i=1 at a clk_i edge):
  - all outputs go to 0; FSM goes to IDLE; counters clear.
  - reset mid-frame discards the partial frame, and no frame is delivered for it.
  - reset has priority over every other input.
- Timing base:
  - FSM, tick counter and samples advance only on cycles with rx_ce_i=1; otherwise all state holds.
  - tick_cnt has width clog2(OVS) and counts 0..OVS-1 within each bit.
- Sampling:
  - rxd_i is sampled at tick_cnt = OVS/2-1, OVS/2 and OVS/2+1.
  - the bit value is the majority of the three samples, decided at tick_cnt = OVS/2+1.
  - the next bit starts when tick_cnt wraps from OVS-1 to 0.
- States:
  - IDLE: on a rx_ce_i tick with rxd_i=0, go to START with tick_cnt=0.
  - START: at the decision point, a value of 1 is a false start: return to IDLE with no output and no flags. A value of 0 continues; at the wrap go to DATA with bit_cnt=0.
  - DATA: each decided bit is shifted in LSB-first. After bit DATA_W-1 wraps, go to PARITY if PARITY!=0, otherwise go to STOP.
  - PARITY:
    - expected value: even = XOR of data bits; odd = inverted XOR; mark = 1; space = 0.
    - perr = (decided value != expected).
    - at the wrap, go to STOP.
  - STOP:
    - checks STOP_BITS bits; any bit decided 0 sets ferr.
    - intermediate stop bits advance at the wrap.
    - the last stop bit completes the frame at its decision point, not at the wrap, so a start edge in the second half of the stop bit is caught.
    - after completion, go to BRK if the frame is a break, otherwise go to IDLE.
  - BRK: wait until rxd_i is high on a rx_ce_i tick, then go to IDLE.
- Break:
  - a break is a frame where all data bits, the parity bit (if present) and the last stop bit are decided 0.
  - break_o goes high at frame completion and stays high while in BRK; it falls when BRK exits.
  - the break frame is delivered as data 0 with frame_err_o=1.
- Holding register (updates the cycle after completion; call that cycle C):
  - if rx_valid_o=0, or rx_valid_o=1 and rx_ready_i=1 in cycle C: load data, perr and ferr, and set rx_valid_o=1.
  - if rx_valid_o=1 and rx_ready_i=0: keep the old frame and set overrun_o=1.
  - otherwise, rx_valid_o clears on rx_ready_i=1.
  - err_clr_i=1 clears overrun_o; if err_clr_i and a new overrun occur in the same cycle, the overrun wins.
  - flags reflect the held frame only and are not sticky, except overrun_o.
- busy_o is high in every state other than IDLE.

Test Plan:
- Default config, frame 0xA5, parity 0, stop 1,1, OVS=16 -> rx_valid_o=1 with rx_data_o=0xA5 and no flags. Valid occurs 9 ticks into the last stop bit. rx_ready_i=1 clears valid on the next clock.
- Start-bit low pulse of 5 ticks, then line high -> no rx_valid_o; busy_o returns to 0 after the START decision point (tick 9).
- One-tick high glitch at tick OVS/2 of data bit 3 in frame 0x00 -> majority vote rejects the glitch, rx_data_o=0x00, no errors.
- Space parity with parity bit sent as 1, data 0x3C -> rx_data_o=0x3C, parity_err_o=1. With PARITY=1 and data 0x07 plus parity bit 1 -> parity_err_o=0.
- First stop bit low, second stop bit high -> frame_err_o=1. Line held low for 15 bit periods -> break_o=1, rx_data_o=0, frame_err_o=1; break_o falls after the line returns high.
- Two frames 0x11 then 0x22 with rx_ready_i=0 -> rx_data_o=0x11 retained, overrun_o=1. err_clr_i pulse -> overrun_o=0. Assert rstn_i mid-frame -> all outputs 0 and no delivery of that frame.

Source files
------------

// File: rtl/is_uart_rx_ovs.sv
// Oversampled UART receiver: 3-sample majority vote at mid-bit, false-start rejection,
// configurable data width / parity / stop bits, single-entry valid/ready holding register.
module is_uart_rx_ovs #(
    parameter int DATA_W    = 8,
    parameter int OVS       = 16,
    parameter int PARITY    = 4,
    parameter int STOP_BITS = 2
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              rxd_i,
    input  logic              rx_ce_i,
    input  logic              rx_ready_i,
    input  logic              err_clr_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              break_o,
    output logic              busy_o
);
    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W);
    localparam logic [TW-1:0] T_S0  = TW'(OVS/2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVS/2);
    localparam logic [TW-1:0] T_DEC = TW'(OVS/2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK
    } state_t;

    state_t            r_state;
    logic [TW-1:0]     r_tick;
    logic [BW-1:0]     r_bit;
    logic              r_stop;
    logic              r_s0;
    logic              r_s1;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_bit;
    logic              r_perr;
    logic              r_ferr;
    logic              r_cmp;
    logic              r_cmp_perr;
    logic              r_cmp_ferr;
    logic              r_brk;

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_hperr;
    logic              r_hferr;
    logic              r_ovr;

    logic w_maj;
    logic w_mid;
    logic w_wrap;
    logic w_par_exp;
    logic w_is_brk;

    // The third sample is the live line value at the decision tick.
    assign w_maj  = (r_s0 & r_s1) | (r_s0 & rxd_i) | (r_s1 & rxd_i);
    assign w_mid  = (r_tick == T_DEC);
    assign w_wrap = (r_tick == T_END);

    always_comb begin
        w_par_exp = 1'b0;
        case (PARITY)
            1:       w_par_exp = ^r_shift;
            2:       w_par_exp = ~^r_shift;
            3:       w_par_exp = 1'b1;
            default: w_par_exp = 1'b0;
        endcase
    end

    assign w_is_brk = (r_shift == '0) && ((PARITY == 0) || !r_par_bit) && !w_maj;

    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_bit      <= '0;
            r_stop     <= 1'b0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_cmp      <= 1'b0;
            r_cmp_perr <= 1'b0;
            r_cmp_ferr <= 1'b0;
            r_brk      <= 1'b0;
        end else begin
            r_cmp <= 1'b0;
            if (rx_ce_i) begin
                if (r_state != S_IDLE && r_state != S_BRK) begin
                    r_tick <= w_wrap ? '0 : r_tick + 1'b1;
                    if (r_tick == T_S0) r_s0 <= rxd_i;
                    if (r_tick == T_S1) r_s1 <= rxd_i;
                end
                case (r_state)
                    S_IDLE: begin
                        if (!rxd_i) begin
                            r_state   <= S_START;
                            r_tick    <= '0;
                            r_stop    <= 1'b0;
                            r_par_bit <= 1'b0;
                            r_perr    <= 1'b0;
                            r_ferr    <= 1'b0;
                        end
                    end
                    S_START: begin
                        if (w_mid && w_maj) begin
                            r_state <= S_IDLE;
                        end else if (w_wrap) begin
                            r_state <= S_DATA;
                            r_bit   <= '0;
                        end
                    end
                    S_DATA: begin
                        if (w_mid) r_shift <= {w_maj, r_shift[DATA_W-1:1]};
                        if (w_wrap) begin
                            if (r_bit == BIT_LAST) r_state <= (PARITY != 0) ? S_PAR : S_STOP;
                            else                   r_bit   <= r_bit + 1'b1;
                        end
                    end
                    S_PAR: begin
                        if (w_mid) begin
                            r_par_bit <= w_maj;
                            r_perr    <= (w_maj != w_par_exp);
                        end
                        if (w_wrap) r_state <= S_STOP;
                    end
                    S_STOP: begin
                        // The last stop bit completes at mid-bit so a following start edge is not missed.
                        if (w_mid) begin
                            if (!w_maj) r_ferr <= 1'b1;
                            if (r_stop == STOP_LAST) begin
                                r_cmp      <= 1'b1;
                                r_cmp_perr <= r_perr;
                                r_cmp_ferr <= r_ferr | ~w_maj;
                                if (w_is_brk) begin
                                    r_state <= S_BRK;
                                    r_brk   <= 1'b1;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end
                        end else if (w_wrap) begin
                            r_stop <= ~r_stop;
                        end
                    end
                    S_BRK: begin
                        if (rxd_i) begin
                            r_state <= S_IDLE;
                            r_brk   <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_hperr <= 1'b0;
            r_hferr <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (r_cmp && (!r_valid || rx_ready_i)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_hperr <= r_cmp_perr;
                r_hferr <= r_cmp_ferr;
            end else if (r_valid && rx_ready_i) begin
                r_valid <= 1'b0;
                r_hperr <= 1'b0;
                r_hferr <= 1'b0;
            end
            // A fresh overrun outranks a simultaneous clear request.
            if (r_cmp && r_valid && !rx_ready_i) r_ovr <= 1'b1;
            else if (err_clr_i)                  r_ovr <= 1'b0;
        end
    end

    assign rx_data_o    = r_data;
    assign rx_valid_o   = r_valid;
    assign parity_err_o = r_hperr;
    assign frame_err_o  = r_hferr;
    assign overrun_o    = r_ovr;
    assign break_o      = r_brk;
    assign busy_o       = (r_state != S_IDLE);
endmodule

// File: tb/tb_is_uart_rx_ovs.sv
// Directed bench for is_uart_rx_ovs: a space-parity instance and an even-parity instance
// share one serial line; frames are built tick by tick on the oversampling strobe.
module tb_is_uart_rx_ovs;
    localparam int OVS = 16;

    logic       clk = 1'b0;
    logic       rstn_i = 1'b1;
    logic       rxd_i = 1'b1;
    logic       rx_ready_i = 1'b0;
    logic       err_clr_i = 1'b0;
    logic [1:0] ce_cnt = 2'd0;
    logic       rx_ce_i;

    logic [7:0] d_data, e_data;
    logic d_valid, d_perr, d_ferr, d_ovr, d_brk, d_busy;
    logic e_valid, e_perr, e_ferr, e_ovr, e_brk, e_busy;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ce_cnt <= ce_cnt + 2'd1;
    assign rx_ce_i = (ce_cnt == 2'd0);

    is_uart_rx_ovs #(.DATA_W(8), .OVS(OVS), .PARITY(4), .STOP_BITS(2)) u_dut (
        .clk_i(clk), .rstn_i(rstn_i), .rxd_i(rxd_i), .rx_ce_i(rx_ce_i),
        .rx_ready_i(rx_ready_i), .err_clr_i(err_clr_i),
        .rx_data_o(d_data), .rx_valid_o(d_valid), .parity_err_o(d_perr),
        .frame_err_o(d_ferr), .overrun_o(d_ovr), .break_o(d_brk), .busy_o(d_busy)
    );

    is_uart_rx_ovs #(.DATA_W(8), .OVS(OVS), .PARITY(1), .STOP_BITS(2)) u_even (
        .clk_i(clk), .rstn_i(rstn_i), .rxd_i(rxd_i), .rx_ce_i(rx_ce_i),
        .rx_ready_i(rx_ready_i), .err_clr_i(err_clr_i),
        .rx_data_o(e_data), .rx_valid_o(e_valid), .parity_err_o(e_perr),
        .frame_err_o(e_ferr), .overrun_o(e_ovr), .break_o(e_brk), .busy_o(e_busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; holds the line at v for exactly one strobe tick.
    task automatic line_tick(input logic v);
        rxd_i = v;
        while (!rx_ce_i) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        repeat (OVS) line_tick(v);
    endtask

    // Sends start, data, parity, first stop and the last stop bit up to its decision tick.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic s1, input int glitch);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch) begin
                for (int t = 0; t < OVS; t++) line_tick((t == OVS/2) ? 1'b1 : d[i]);
            end else begin
                send_bit(d[i]);
            end
        end
        send_bit(par);
        send_bit(s1);
        repeat (OVS/2 + 3) line_tick(1'b1);
    endtask

    task automatic finish_stop();
        repeat (OVS/2 - 3) line_tick(1'b1);
    endtask

    task automatic consume(input string tag);
        rx_ready_i = 1'b1;
        @(negedge clk);
        rx_ready_i = 1'b0;
        check(tag, d_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        check("rst_valid", d_valid, 1'b0);
        check("rst_data",  d_data,  8'h00);
        check("rst_ovr",   d_ovr,   1'b0);
        check("rst_brk",   d_brk,   1'b0);
        check("rst_busy",  d_busy,  1'b0);
        rstn_i = 1'b0;
        repeat (4) @(negedge clk);

        // Basic frame: holding register loads one cycle after completion.
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        check("a5_pre_valid", d_valid, 1'b0);
        check("a5_busy_done", d_busy,  1'b0);
        @(negedge clk);
        check("a5_valid", d_valid, 1'b1);
        check("a5_data",  d_data,  8'hA5);
        check("a5_perr",  d_perr,  1'b0);
        check("a5_ferr",  d_ferr,  1'b0);
        check("a5_ovr",   d_ovr,   1'b0);
        check("a5_even_perr", e_perr, 1'b0);
        finish_stop();
        consume("a5_consume");

        // False start: 5 low ticks, rejected at the START decision point.
        repeat (5) line_tick(1'b0);
        repeat (5) line_tick(1'b1);
        check("fs_busy_before", d_busy, 1'b1);
        line_tick(1'b1);
        check("fs_busy_after", d_busy, 1'b0);
        repeat (3 * OVS) line_tick(1'b1);
        check("fs_no_valid", d_valid, 1'b0);

        // Single-tick glitch inside data bit 3 is outvoted.
        send_frame(8'h00, 1'b0, 1'b1, 3);
        @(negedge clk);
        check("gl_valid", d_valid, 1'b1);
        check("gl_data",  d_data,  8'h00);
        check("gl_perr",  d_perr,  1'b0);
        check("gl_ferr",  d_ferr,  1'b0);
        finish_stop();
        consume("gl_consume");

        // Space parity violated; the even instance also sees a mismatch for 0x3C.
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        @(negedge clk);
        check("sp_data", d_data, 8'h3C);
        check("sp_perr", d_perr, 1'b1);
        check("sp_ferr", d_ferr, 1'b0);
        check("sp_even_perr", e_perr, 1'b1);
        finish_stop();
        consume("sp_consume");

        send_frame(8'h07, 1'b1, 1'b1, -1);
        @(negedge clk);
        check("ev_data", e_data, 8'h07);
        check("ev_perr", e_perr, 1'b0);
        check("ev_space_perr", d_perr, 1'b1);
        finish_stop();
        consume("ev_consume");

        // First stop bit low.
        send_frame(8'h5A, 1'b0, 1'b0, -1);
        @(negedge clk);
        check("fe_data", d_data, 8'h5A);
        check("fe_ferr", d_ferr, 1'b1);
        check("fe_perr", d_perr, 1'b0);
        check("fe_brk",  d_brk,  1'b0);
        finish_stop();
        consume("fe_consume");

        // Break: line low for 15 bit periods.
        repeat (15 * OVS) line_tick(1'b0);
        check("br_brk",   d_brk,   1'b1);
        check("br_busy",  d_busy,  1'b1);
        check("br_valid", d_valid, 1'b1);
        check("br_data",  d_data,  8'h00);
        check("br_ferr",  d_ferr,  1'b1);
        line_tick(1'b1);
        check("br_brk_fall", d_brk,  1'b0);
        check("br_idle",     d_busy, 1'b0);
        repeat (OVS) line_tick(1'b1);
        consume("br_consume");

        // Overrun: second frame dropped while the first is unread.
        send_frame(8'h11, 1'b0, 1'b1, -1);
        finish_stop();
        send_frame(8'h22, 1'b0, 1'b1, -1);
        @(negedge clk);
        check("ov_flag",  d_ovr,   1'b1);
        check("ov_data",  d_data,  8'h11);
        check("ov_valid", d_valid, 1'b1);
        finish_stop();
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        check("ov_clr",      d_ovr,  1'b0);
        check("ov_clr_data", d_data, 8'h11);

        // Clear request in the same cycle as a new overrun: overrun wins.
        send_frame(8'h33, 1'b0, 1'b1, -1);
        err_clr_i = 1'b1;
        @(negedge clk);
        check("ov_tie", d_ovr, 1'b1);
        @(negedge clk);
        err_clr_i = 1'b0;
        check("ov_tie_clr", d_ovr, 1'b0);
        check("ov_tie_data", d_data, 8'h11);
        finish_stop();

        // Reset mid-frame with a held frame present; reset overrides a low line.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rstn_i = 1'b1;
        repeat (8) @(negedge clk);
        check("mr_valid", d_valid, 1'b0);
        check("mr_data",  d_data,  8'h00);
        check("mr_busy",  d_busy,  1'b0);
        check("mr_ovr",   d_ovr,   1'b0);
        check("mr_ferr",  d_ferr,  1'b0);
        rxd_i = 1'b1;
        rstn_i = 1'b0;
        repeat (12 * OVS) line_tick(1'b1);
        check("mr_no_deliver", d_valid, 1'b0);
        check("mr_idle",       d_busy,  1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
